// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter and the CPU controller that drives it.
// Provides the state codes, the requester-id codes and a counter-width helper.
// No logic; imported by mem_port_arbiter.
package mem_port_arbiter_pkg;

    // Arbiter state encodings
    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_ACCESS = 1'b1;

    // Requester ids
    localparam logic [0:0] ARB_FETCH  = 1'b0;
    localparam logic [0:0] ARB_DATA   = 1'b1;

    // Bits needed to hold 0..max_val. A zero-width counter is illegal,
    // so the result is never below 1 (e.g. a strict-priority streak counter).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch and LD/ST data requesters.
// Latency : request sampled at edge k, ack pulses the cycle after edge k+MEM_LATENCY.
// Backpressure: requesters hold req until ack; one access per MEM_LATENCY+1 cycles.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   f_req/f_addr           fetch request (read only) -> f_ack pulse, f_rdata held
//   d_req/d_we/d_addr/d_wdata  data request (load/store) -> d_ack pulse, d_rdata held
//   mem_addr/mem_wdata/mem_write/mem_rdata  shared memory port
//   busy                   an access is in flight
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = cnt_width(MEM_LATENCY);
    localparam int SW = cnt_width(STARVE_LIMIT);

    localparam logic [CW-1:0] LAT_LAST  = CW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam bit            STARVE_EN  = (STARVE_LIMIT != 0);

    logic [0:0]        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [SW-1:0]     streak_q,  streak_d;
    logic [0:0]        win_q,     win_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              write_q,   write_d;
    logic              f_ack_q,   f_ack_d;
    logic              d_ack_q,   d_ack_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic fetch_forced;
    logic grant_data;

    // Fetch overrides data only once the streak of data grants made against
    // a waiting fetch has reached the limit.
    always_comb begin
        fetch_forced = f_req && STARVE_EN && (streak_q == STARVE_MAX);
        grant_data   = d_req && !fetch_forced;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                // A fetch that is not waiting has nothing to be starved of.
                if (!f_req) begin
                    streak_d = '0;
                end
                if (f_req || d_req) begin
                    state_d = ARB_ACCESS;
                    cnt_d   = LAT_LAST;
                    if (grant_data) begin
                        win_d   = ARB_DATA;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        write_d = d_we;
                        // Saturating count; with strict priority it sits at 0.
                        if (f_req && (streak_q != STARVE_MAX)) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else begin
                        win_d    = ARB_FETCH;
                        addr_d   = f_addr;
                        wdata_d  = '0;
                        write_d  = 1'b0;
                        streak_d = '0;
                    end
                end
            end

            ARB_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ARB_IDLE;
                    write_d = 1'b0;
                    if (win_q == ARB_DATA) begin
                        d_ack_d = 1'b1;
                        // write_q still marks a store in this final cycle
                        if (!write_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        f_ack_d   = 1'b1;
                        f_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            win_q     <= ARB_FETCH;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_write = write_q;
    assign busy      = (state_q == ARB_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 / starve limit 3, and
// latency 3 / strict data priority) driven by directed steps then random traffic,
// each compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int N = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst       [N];
    logic       f_req     [N];
    logic [7:0] f_addr    [N];
    logic       d_req     [N];
    logic       d_we      [N];
    logic [7:0] d_addr    [N];
    logic [7:0] d_wdata   [N];
    logic [7:0] mem_rdata [N];

    wire        f_ack     [N];
    wire  [7:0] f_rdata   [N];
    wire        d_ack     [N];
    wire  [7:0] d_rdata   [N];
    wire  [7:0] mem_addr  [N];
    wire  [7:0] mem_wdata [N];
    wire        mem_write [N];
    wire        busy      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W      (8),
            .DATA_W      (8),
            .MEM_LATENCY ((g == 0) ? 1 : 3),
            .STARVE_LIMIT((g == 0) ? 3 : 0)
        ) u_dut (
            .clock    (clock),
            .reset    (rst[g]),
            .f_req    (f_req[g]),
            .f_addr   (f_addr[g]),
            .f_ack    (f_ack[g]),
            .f_rdata  (f_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_ack    (d_ack[g]),
            .d_rdata  (d_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_write(mem_write[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int slim(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    // Reference model: one outstanding transaction per instance, completing at
    // an absolute cycle number (grant cycle + latency).
    bit         m_inflight [N];
    int         m_done     [N];
    bit         m_is_data  [N];
    bit         m_store    [N];
    logic [7:0] m_addr     [N];
    logic [7:0] m_wdata    [N];
    bit         m_write    [N];
    bit         m_fack     [N];
    bit         m_dack     [N];
    logic [7:0] m_frdata   [N];
    logic [7:0] m_drdata   [N];
    int         m_streak   [N];
    int         cyc = 0;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    endtask

    task automatic model_edge();
        bit fetch_turn;
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                m_inflight[i] = 1'b0;
                m_fack[i]     = 1'b0;
                m_dack[i]     = 1'b0;
                m_frdata[i]   = 8'h00;
                m_drdata[i]   = 8'h00;
                m_addr[i]     = 8'h00;
                m_wdata[i]    = 8'h00;
                m_write[i]    = 1'b0;
                m_streak[i]   = 0;
            end else begin
                m_fack[i] = 1'b0;
                m_dack[i] = 1'b0;
                if (m_inflight[i]) begin
                    if (cyc == m_done[i]) begin
                        m_inflight[i] = 1'b0;
                        m_write[i]    = 1'b0;
                        if (m_is_data[i]) begin
                            m_dack[i] = 1'b1;
                            if (!m_store[i]) m_drdata[i] = mem_rdata[i];
                        end else begin
                            m_fack[i]   = 1'b1;
                            m_frdata[i] = mem_rdata[i];
                        end
                    end
                end else begin
                    if (!f_req[i]) m_streak[i] = 0;
                    if (f_req[i] || d_req[i]) begin
                        fetch_turn = f_req[i] && (slim(i) != 0) && (m_streak[i] >= slim(i));
                        if (d_req[i] && !fetch_turn) begin
                            m_is_data[i] = 1'b1;
                            m_store[i]   = d_we[i];
                            m_addr[i]    = d_addr[i];
                            m_wdata[i]   = d_wdata[i];
                            m_write[i]   = d_we[i];
                            if (f_req[i] && m_streak[i] < slim(i)) m_streak[i] = m_streak[i] + 1;
                        end else begin
                            m_is_data[i] = 1'b0;
                            m_store[i]   = 1'b0;
                            m_addr[i]    = f_addr[i];
                            m_wdata[i]   = 8'h00;
                            m_write[i]   = 1'b0;
                            m_streak[i]  = 0;
                        end
                        m_inflight[i] = 1'b1;
                        m_done[i]     = cyc + lat(i);
                    end
                end
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            chk("f_ack",     i, f_ack[i],     m_fack[i]);
            chk("d_ack",     i, d_ack[i],     m_dack[i]);
            chk("f_rdata",   i, f_rdata[i],   m_frdata[i]);
            chk("d_rdata",   i, d_rdata[i],   m_drdata[i]);
            chk("mem_addr",  i, mem_addr[i],  m_addr[i]);
            chk("mem_write", i, mem_write[i], m_write[i]);
            chk("busy",      i, busy[i],      m_inflight[i]);
            chk("ack_excl",  i, f_ack[i] & d_ack[i], 0);
            if (m_write[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
        end
    endtask

    // One clock: model advances at the edge, outputs compared half a cycle later.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle_inputs(input int i);
        f_req[i]   = 1'b0;
        f_addr[i]  = 8'h00;
        d_req[i]   = 1'b0;
        d_we[i]    = 1'b0;
        d_addr[i]  = 8'h00;
        d_wdata[i] = 8'h00;
    endtask

    initial begin
        byte   seq[$];
        string exp_order;
        int    guard;
        int    fcount;
        bit    got;
        bit    saw_store;

        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            idle_inputs(i);
            mem_rdata[i] = 8'h00;
        end
        @(negedge clock);
        step();
        step();
        chk("rst_busy",  0, busy[0], 0);
        chk("rst_maddr", 1, mem_addr[1], 8'h00);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Fetch only, latency 1
        f_req[0] = 1'b1; f_addr[0] = 8'h10; mem_rdata[0] = 8'hA5;
        step();
        chk("t1_addr", 0, mem_addr[0], 8'h10);
        chk("t1_busy", 0, busy[0], 1);
        chk("t1_wr",   0, mem_write[0], 0);
        f_req[0] = 1'b0;
        step();
        chk("t1_ack",   0, f_ack[0], 1);
        chk("t1_rdata", 0, f_rdata[0], 8'hA5);
        chk("t1_wr2",   0, mem_write[0], 0);

        // Store, latency 1
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h20; d_wdata[0] = 8'h3C;
        step();
        chk("t2_wr",    0, mem_write[0], 1);
        chk("t2_addr",  0, mem_addr[0], 8'h20);
        chk("t2_wdata", 0, mem_wdata[0], 8'h3C);
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        step();
        chk("t2_ack",   0, d_ack[0], 1);
        chk("t2_wr_off",0, mem_write[0], 0);
        chk("t2_rdata", 0, d_rdata[0], 8'h00);

        // Load with latency 3; request dropped and address wobbled mid-access
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h40; mem_rdata[1] = 8'h11;
        step();
        d_req[1] = 1'b0; d_addr[1] = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            chk("t4_busy", 1, busy[1], 1);
            chk("t4_addr", 1, mem_addr[1], 8'h40);
            mem_rdata[1] = 8'h22 + 8'(c * 17);
            step();
        end
        chk("t4_ack",   1, d_ack[1], 1);
        chk("t4_rdata", 1, d_rdata[1], 8'h44);
        chk("t4_idle",  1, busy[1], 0);

        // Both held, starve limit 3
        f_req[0] = 1'b1; f_addr[0] = 8'h30;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h31;
        guard = 0;
        while (seq.size() < 8 && guard < 40) begin
            step();
            guard++;
            if (f_ack[0]) seq.push_back("F");
            if (d_ack[0]) seq.push_back("D");
        end
        f_req[0] = 1'b0; d_req[0] = 1'b0;
        exp_order = "DDDFDDDF";
        chk("t3_count", 0, seq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t3_order", 0, (k < seq.size()) ? seq[k] : 8'h00, exp_order[k]);
        end
        step();

        // Strict data priority, latency 3
        f_req[1] = 1'b1; f_addr[1] = 8'h50;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h51;
        fcount = 0;
        repeat (16) begin
            step();
            if (f_ack[1]) fcount++;
        end
        chk("t6_no_fetch", 1, fcount, 0);
        d_req[1] = 1'b0;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 12) begin
            step();
            guard++;
            got = f_ack[1];
        end
        chk("t6_fetch_served", 1, got, 1);
        f_req[1] = 1'b0;

        // Reset in the middle of a store
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 8'h55; d_wdata[1] = 8'h77;
        step();
        chk("t5_wr", 1, mem_write[1], 1);
        step();
        rst[1] = 1'b1;
        step();
        chk("t5_rst_wr",   1, mem_write[1], 0);
        chk("t5_rst_busy", 1, busy[1], 0);
        chk("t5_rst_ack",  1, d_ack[1], 0);
        chk("t5_rst_addr", 1, mem_addr[1], 8'h00);
        rst[1] = 1'b0;
        got = 1'b0;
        saw_store = 1'b0;
        guard = 0;
        while (!got && guard < 12) begin
            step();
            guard++;
            if (mem_write[1] && mem_addr[1] == 8'h55) saw_store = 1'b1;
            got = d_ack[1];
        end
        chk("t5_reserved",  1, got, 1);
        chk("t5_saw_store", 1, saw_store, 1);
        d_req[1] = 1'b0; d_we[1] = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                rst[i] = ($urandom_range(0, 99) == 0);
                if (!f_req[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        f_req[i]  = 1'b1;
                        f_addr[i] = 8'($urandom);
                    end
                end else if (m_fack[i]) begin
                    if ($urandom_range(0, 2) == 0) f_req[i] = 1'b0;
                    else f_addr[i] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    f_req[i] = 1'b0;
                end
                if (!d_req[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_req[i]   = 1'b1;
                        d_we[i]    = 1'($urandom_range(0, 1));
                        d_addr[i]  = 8'($urandom);
                        d_wdata[i] = 8'($urandom);
                    end
                end else if (m_dack[i]) begin
                    if ($urandom_range(0, 2) == 0) d_req[i] = 1'b0;
                    else begin
                        d_we[i]    = 1'($urandom_range(0, 1));
                        d_addr[i]  = 8'($urandom);
                        d_wdata[i] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req[i] = 1'b0;
                end
                if ($urandom_range(0, 7) == 0) d_addr[i] = 8'($urandom);
                mem_rdata[i] = 8'($urandom);
            end
            step();
        end

        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0;
            idle_inputs(i);
        end
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
